// File: rtl/weight_preload_ctrl_if.sv
// Handshake, BRAM read port and preload-lane signals of the 5x5 weight preload controller.
interface weight_preload_ctrl_if;
  logic       start;
  logic [9:0] base_addr;
  logic       abort;
  logic       busy;
  logic       done;
  logic       bram_en;
  logic [9:0] bram_addr;
  logic [4:0] bram_dout;
  logic [4:0] weight_to_preload;
  logic       load_weight_preload;

  modport slave (
    input  start,
    input  base_addr,
    input  abort,
    input  bram_dout,
    output busy,
    output done,
    output bram_en,
    output bram_addr,
    output weight_to_preload,
    output load_weight_preload
  );

  modport master (
    output start,
    output base_addr,
    output abort,
    output bram_dout,
    input  busy,
    input  done,
    input  bram_en,
    input  bram_addr,
    input  weight_to_preload,
    input  load_weight_preload
  );
endinterface

// File: rtl/weight_preload_ctrl.sv
// Reads the five columns of one 5x5 kernel from BRAM and streams them, in ascending address
// order, into the weight preload shift lanes (one bit per lane per load).
module weight_preload_ctrl (
  input  logic                  clk,
  input  logic                  rst_n,
  weight_preload_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [9:0] base_q, base_d;
  logic [9:0] addr_q, addr_d;
  logic       load_q, load_d;
  logic [2:0] cnt_inc;

  assign cnt_inc = cnt_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      base_q  <= 10'd0;
      addr_q  <= 10'd0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    addr_d  = addr_q;
    load_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // start beats a simultaneous abort here: abort only cancels an active fetch
        if (bus.start) begin
          base_d  = bus.base_addr;
          addr_d  = bus.base_addr;
          cnt_d   = 3'd0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // data read in an aborted cycle is dropped, so it never reaches the lanes
        load_d = ~bus.abort;
        if (bus.abort) begin
          state_d = StIdle;
        end else if (cnt_q == 3'd4) begin
          state_d = StDrain;
        end else begin
          cnt_d  = cnt_inc;
          addr_d = base_q + 10'(cnt_inc);
        end
      end
      StDrain: begin
        state_d = bus.abort ? StIdle : StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.busy                = (state_q != StIdle);
  assign bus.done                = (state_q == StDone);
  assign bus.bram_en             = (state_q == StFetch);
  assign bus.bram_addr           = addr_q;
  assign bus.load_weight_preload = load_q;
  assign bus.weight_to_preload   = load_q ? bus.bram_dout : 5'b00000;

endmodule

// File: tb/tb_weight_preload_ctrl.sv
// Directed cycle table plus reset and random-base lane scoreboard for weight_preload_ctrl.
module tb_weight_preload_ctrl;

  logic clk;
  logic rst_n;

  weight_preload_ctrl_if bus ();

  weight_preload_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] mem [1024];

  // BRAM model: one-cycle read latency
  always @(posedge clk) begin
    if (bus.bram_en) bus.bram_dout <= mem[bus.bram_addr];
  end

  typedef struct {
    logic       start;
    logic       abort;
    logic [9:0] base;
    logic       busy;
    logic       done;
    logic       en;
    logic [9:0] addr;
    logic       ld;
    logic [4:0] wt;
  } vec_t;

  vec_t vecs[$];
  int   passed;
  int   total;

  task automatic add(input logic st, input logic ab, input logic [9:0] b, input logic bsy,
                     input logic dn, input logic en, input logic [9:0] a, input logic ld,
                     input logic [4:0] wt);
    vec_t v;
    v.start = st; v.abort = ab; v.base = b;
    v.busy = bsy; v.done = dn; v.en = en; v.addr = a; v.ld = ld; v.wt = wt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, bus.busy, bus.done, bus.bram_en, bus.bram_addr, bus.load_weight_preload,
            bus.weight_to_preload};
  endfunction

  initial begin
    logic [4:0][4:0] lanes;
    logic [4:0][4:0] exp_l;
    logic [9:0]      base;
    logic [9:0]      a;
    int              loads;
    logic            got_done;

    passed = 0;
    total  = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 5'(i);
    bus.bram_dout = 5'd0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_addr = 10'd0;

    // nominal, base 0x010
    add(1,0,10'h010, 0,0,0,10'h000,0,5'h00);
    add(0,0,10'h000, 1,0,1,10'h010,0,5'h00);
    add(0,0,10'h000, 1,0,1,10'h011,1,5'h10);
    add(0,0,10'h000, 1,0,1,10'h012,1,5'h11);
    add(0,0,10'h000, 1,0,1,10'h013,1,5'h12);
    add(0,0,10'h000, 1,0,1,10'h014,1,5'h13);
    add(0,0,10'h000, 1,0,0,10'h014,1,5'h14);
    add(0,0,10'h000, 1,1,0,10'h014,0,5'h00);
    // address wrap, base 0x3FE
    add(1,0,10'h3FE, 0,0,0,10'h014,0,5'h00);
    add(0,0,10'h000, 1,0,1,10'h3FE,0,5'h00);
    add(0,0,10'h000, 1,0,1,10'h3FF,1,5'h1E);
    add(0,0,10'h000, 1,0,1,10'h000,1,5'h1F);
    add(0,0,10'h000, 1,0,1,10'h001,1,5'h00);
    add(0,0,10'h000, 1,0,1,10'h002,1,5'h01);
    add(0,0,10'h000, 1,0,0,10'h002,1,5'h02);
    add(0,0,10'h000, 1,1,0,10'h002,0,5'h00);
    // start held high: busy-state starts ignored, restart one cycle after DONE
    add(1,0,10'h100, 0,0,0,10'h002,0,5'h00);
    add(1,0,10'h200, 1,0,1,10'h100,0,5'h00);
    add(1,0,10'h200, 1,0,1,10'h101,1,5'h00);
    add(1,0,10'h200, 1,0,1,10'h102,1,5'h01);
    add(1,0,10'h200, 1,0,1,10'h103,1,5'h02);
    add(1,0,10'h200, 1,0,1,10'h104,1,5'h03);
    add(1,0,10'h200, 1,0,0,10'h104,1,5'h04);
    add(1,0,10'h200, 1,1,0,10'h104,0,5'h00);
    add(1,0,10'h040, 0,0,0,10'h104,0,5'h00);
    // second preload aborted in T3
    add(0,0,10'h000, 1,0,1,10'h040,0,5'h00);
    add(0,0,10'h000, 1,0,1,10'h041,1,5'h00);
    add(0,1,10'h000, 1,0,1,10'h042,1,5'h01);
    add(0,0,10'h000, 0,0,0,10'h042,0,5'h00);
    // start and abort together in idle: start wins; then abort in DRAIN
    add(1,1,10'h0AA, 0,0,0,10'h042,0,5'h00);
    add(0,0,10'h000, 1,0,1,10'h0AA,0,5'h00);
    add(0,0,10'h000, 1,0,1,10'h0AB,1,5'h0A);
    add(0,0,10'h000, 1,0,1,10'h0AC,1,5'h0B);
    add(0,0,10'h000, 1,0,1,10'h0AD,1,5'h0C);
    add(0,0,10'h000, 1,0,1,10'h0AE,1,5'h0D);
    add(0,1,10'h000, 1,0,0,10'h0AE,1,5'h0E);
    add(0,0,10'h000, 0,0,0,10'h0AE,0,5'h00);
    add(0,0,10'h000, 0,0,0,10'h0AE,0,5'h00);
    // abort in DONE has no effect
    add(1,0,10'h1F0, 0,0,0,10'h0AE,0,5'h00);
    add(0,0,10'h000, 1,0,1,10'h1F0,0,5'h00);
    add(0,0,10'h000, 1,0,1,10'h1F1,1,5'h10);
    add(0,0,10'h000, 1,0,1,10'h1F2,1,5'h11);
    add(0,0,10'h000, 1,0,1,10'h1F3,1,5'h12);
    add(0,0,10'h000, 1,0,1,10'h1F4,1,5'h13);
    add(0,0,10'h000, 1,0,0,10'h1F4,1,5'h14);
    add(0,1,10'h000, 1,1,0,10'h1F4,0,5'h00);
    add(0,0,10'h000, 0,0,0,10'h1F4,0,5'h00);
    add(0,0,10'h000, 0,0,0,10'h1F4,0,5'h00);

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_async", outs(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i), outs(),
            {13'd0, vecs[i].busy, vecs[i].done, vecs[i].en, vecs[i].addr, vecs[i].ld, vecs[i].wt});
      bus.start     = vecs[i].start;
      bus.abort     = vecs[i].abort;
      bus.base_addr = vecs[i].base;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // reset asserted mid-FETCH, away from any clock edge
    @(posedge clk);
    #1 bus.start = 1'b1; bus.base_addr = 10'h123;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_fetch", outs(), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1 check($sformatf("post_reset_quiet%0d", c), outs(), 32'd0);
    end

    // random bases against a lane shift model
    for (int i = 0; i < 1024; i++) mem[i] = 5'($urandom);
    for (int r = 0; r < 1000; r++) begin
      @(posedge clk);
      #1;
      base          = 10'($urandom_range(1023));
      bus.start     = 1'b1;
      bus.base_addr = base;
      loads         = 0;
      lanes         = '0;
      got_done      = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1 bus.start = 1'b0;
        if (bus.load_weight_preload) begin
          loads++;
          for (int l = 0; l < 5; l++) lanes[l] = {bus.weight_to_preload[l], lanes[l][4:1]};
        end
        if (bus.done) begin
          got_done = 1'b1;
          break;
        end
      end
      for (int l = 0; l < 5; l++) begin
        for (int k = 0; k < 5; k++) begin
          a           = base + 10'(k);
          exp_l[l][k] = mem[a][l];
        end
      end
      check($sformatf("lanes_run%0d_base%h", r, base), {2'd0, got_done, 4'(loads), lanes},
            {2'd0, 1'b1, 4'd5, exp_l});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/weight_preload_ctrl.md
WEIGHT_PRELOAD_CTRL -- requirements
Module: weight_preload_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to preload one 5x5 kernel; sampled each clock.
REQ-005 base_addr  input  10  BRAM address of kernel column 0; sampled with start.
REQ-006 abort  input  1  synchronous cancel of an in-progress preload.
REQ-007 busy  output  1  high while a preload is in progress.
REQ-008 done  output  1  one-cycle pulse when the preload completes.
REQ-009 bram_en  output  1  BRAM read enable.
REQ-010 bram_addr  output  10  BRAM read address.
REQ-011 bram_dout  input  5  BRAM read data, valid exactly 1 cycle after the bram_en cycle.
REQ-012 weight_to_preload  output  5  column data to the weight preload shift lanes; bit i feeds lane i.
REQ-013 load_weight_preload  output  1  shift enable to the weight preload lanes.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, DRAIN and DONE; reset enters IDLE.
REQ-015 In IDLE with start=1 at edge T0, base_addr SHALL be latched, a 3-bit column counter SHALL clear, and the FSM SHALL enter FETCH.
REQ-016 In FETCH, cycles T1..T5, bram_en SHALL be 1 and bram_addr SHALL be (latched base + counter) mod 1024, counter 0..4.
REQ-017 The counter SHALL increment each FETCH cycle; when counter=4 the FSM SHALL go to DRAIN (T6), then DONE (T7), then IDLE.
REQ-018 load_weight_preload SHALL be a 1-cycle-delayed copy of bram_en, high in exactly T2..T6.
REQ-019 weight_to_preload SHALL equal bram_dout when load_weight_preload=1 and SHALL be 5'b00000 otherwise.
REQ-020 Column order SHALL be ascending: the word at base+0 is shifted first, so it ends at bit 0 of every lane after 5 loads.
REQ-021 done SHALL be 1 only in T7 (DONE), after the last load edge at the end of T6.
REQ-022 busy SHALL be 1 in T1..T7 inclusive and 0 in IDLE.
REQ-023 Outside FETCH, bram_en SHALL be 0 and bram_addr SHALL hold its last value.
REQ-024 start SHALL be ignored in every state other than IDLE, including DONE; a start in the cycle after DONE SHALL be accepted.
REQ-025 abort=1 sampled in FETCH or DRAIN SHALL return the FSM to IDLE at that edge.
REQ-026 After an abort, bram_en, load_weight_preload and busy SHALL be 0 from the next cycle; in-flight read data SHALL NOT be loaded and done SHALL NOT pulse.
REQ-027 abort in IDLE or DONE SHALL have no effect; if abort and start are both 1 in IDLE, start SHALL win.
REQ-028 Exactly 5 load pulses SHALL occur per completed preload; never more, and never fewer unless aborted.

Reset
REQ-029 While rst_n=0, regardless of clock: FSM in IDLE, counter=0, latched base=0, busy=0, done=0, bram_en=0, bram_addr=0, load_weight_preload=0, weight_to_preload=0.
REQ-030 Reset asserted mid-preload SHALL abort immediately with no done pulse; operation SHALL resume only on a new start after rst_n rises.

Verification
REQ-031 Reset: assert rst_n=0 mid-FETCH -> all outputs 0 asynchronously; after release, no activity until start.
REQ-032 Nominal: start, base_addr=0x010; BRAM model returns addr[4:0] -> bram_addr 0x010..0x014 in T1..T5, weight_to_preload 0x10..0x14 with load in T2..T6, done in T7, busy T1..T7.
REQ-033 Wrap: base_addr=0x3FE -> bram_addr 0x3FE, 0x3FF, 0x000, 0x001, 0x002.
REQ-034 Start collision: start held high T0..T8 -> second preload begins with T8 as its T0 (bram_en next at T9); starts in T1..T7 ignored.
REQ-035 Abort: abort=1 in T3 -> bram_en=0 and load=0 from T4, busy=0 from T4, no done, only loads in T2..T3 occur.
REQ-036 Scoreboard: a lane model fed by weight_to_preload and load_weight_preload SHALL hold {word4..word0} per lane after done, for random base_addr over 1000 runs.
